bg_line_fetcher: RTL and testbench



---
 rtl/bg_line_fetcher.sv | 220 ++++++++++++++++++++++
 tb/tb_bg_line_fetcher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_line_fetcher.sv
// Background scanline fetcher: walks the BG tile map for one line,
// reads tile rows from VRAM and streams 160 palette-mapped shades.
module bg_line_fetcher #(
    parameter int LINE_WIDTH = 160,
    parameter int VRAM_AW    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         ly,
    input  logic [7:0]         scx,
    input  logic [7:0]         scy,
    input  logic [7:0]         lcdc,
    input  logic [7:0]         bgp,
    output logic               vram_req,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_ack,
    input  logic [7:0]         vram_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [1:0]         pix_data,
    output logic [7:0]         pix_x,
    output logic               busy,
    output logic               line_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_LO,
        S_HI,
        S_PUSH,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] y_q, y_d;
    logic [7:0] scx_q, scx_d;
    logic [7:0] bgp_q, bgp_d;
    logic       bg_en_q, bg_en_d;
    logic       map_hi_q, map_hi_d;
    logic       data_u_q, data_u_d;
    logic [7:0] tnum_q, tnum_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] x_q, x_d;
    logic [4:0] n_q, n_d;
    logic [2:0] pi_q, pi_d;
    logic       gap_q, gap_d;

    logic               unused_lcdc;
    logic [4:0]         col;
    logic [VRAM_AW-1:0] map_addr;
    logic [VRAM_AW-1:0] tile_base;
    logic [VRAM_AW-1:0] row_addr;
    logic [2:0]         bitpos;
    logic [1:0]         idx;
    logic [1:0]         shade;
    logic               last_px;

    assign unused_lcdc = ^{lcdc[7:5], lcdc[2:1]};

    // Tile-map column wraps within the 32-entry map row.
    assign col      = scx_q[7:3] + n_q;
    assign map_addr = (map_hi_q ? VRAM_AW'(16'h1C00) : VRAM_AW'(16'h1800))
                    + VRAM_AW'({y_q[7:3], col});

    // Unsigned tiles from 0x0000, signed tiles centred on 0x1000.
    assign tile_base = data_u_q
                     ? VRAM_AW'({4'h0, tnum_q, 4'h0})
                     : VRAM_AW'(16'h1000 + {{4{tnum_q[7]}}, tnum_q, 4'h0});
    assign row_addr  = tile_base + VRAM_AW'({y_q[2:0], 1'b0});

    // Pixel 0 is the MSB of both bitplanes.
    assign bitpos  = ~pi_q;
    assign idx     = {hi_q[bitpos], lo_q[bitpos]};
    assign shade   = bg_en_q ? bgp_q[{idx, 1'b0} +: 2] : bgp_q[1:0];
    assign last_px = (x_q == 8'(LINE_WIDTH - 1));

    assign pix_x = x_q;

    // Next-state, VRAM request and pixel stream control.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        scx_d     = scx_q;
        bgp_d     = bgp_q;
        bg_en_d   = bg_en_q;
        map_hi_d  = map_hi_q;
        data_u_d  = data_u_q;
        tnum_d    = tnum_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        x_d       = x_q;
        n_d       = n_q;
        pi_d      = pi_q;
        gap_d     = gap_q;
        vram_req  = 1'b0;
        vram_addr = '0;
        pix_valid = 1'b0;
        pix_data  = 2'b00;
        busy      = 1'b0;
        line_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d      = ly + scy;
                    scx_d    = scx;
                    bgp_d    = bgp;
                    bg_en_d  = lcdc[0];
                    map_hi_d = lcdc[3];
                    data_u_d = lcdc[4];
                    x_d      = 8'd0;
                    n_d      = 5'd0;
                    pi_d     = 3'd0;
                    gap_d    = 1'b0;
                    state_d  = lcdc[0] ? S_MAP : S_PUSH;
                end
            end
            S_MAP: begin
                busy      = 1'b1;
                vram_req  = ~gap_q;
                vram_addr = map_addr;
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (vram_ack) begin
                    tnum_d  = vram_data;
                    gap_d   = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                busy      = 1'b1;
                vram_req  = ~gap_q;
                vram_addr = row_addr;
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (vram_ack) begin
                    lo_d    = vram_data;
                    gap_d   = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                busy      = 1'b1;
                vram_req  = ~gap_q;
                vram_addr = row_addr + VRAM_AW'(1);
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (vram_ack) begin
                    hi_d    = vram_data;
                    gap_d   = 1'b0;
                    pi_d    = (n_q == 5'd0) ? scx_q[2:0] : 3'd0;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                pix_data  = shade;
                if (pix_ready) begin
                    if (last_px) begin
                        x_d     = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        x_d = x_q + 8'd1;
                        if (bg_en_q) begin
                            pi_d = pi_q + 3'd1;
                            if (pi_q == 3'd7) begin
                                n_d     = n_q + 5'd1;
                                state_d = S_MAP;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                line_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            y_q      <= 8'd0;
            scx_q    <= 8'd0;
            bgp_q    <= 8'd0;
            bg_en_q  <= 1'b0;
            map_hi_q <= 1'b0;
            data_u_q <= 1'b0;
            tnum_q   <= 8'd0;
            lo_q     <= 8'd0;
            hi_q     <= 8'd0;
            x_q      <= 8'd0;
            n_q      <= 5'd0;
            pi_q     <= 3'd0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            scx_q    <= scx_d;
            bgp_q    <= bgp_d;
            bg_en_q  <= bg_en_d;
            map_hi_q <= map_hi_d;
            data_u_q <= data_u_d;
            tnum_q   <= tnum_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            x_q      <= x_d;
            n_q      <= n_d;
            pi_q     <= pi_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: tb/tb_bg_line_fetcher.sv
// Randomised bench for bg_line_fetcher: VRAM responder with random
// latency, random-ready consumer, per-pixel reference model.
module tb_bg_line_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ly, scx, scy, lcdc, bgp;
    logic        vram_req;
    logic [12:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [1:0]  pix_data;
    logic [7:0]  pix_x;
    logic        busy;
    logic        line_done;

    logic [7:0]  mem [8192];
    int          last_reqs [$];
    logic [1:0]  first_d;
    logic [7:0]  first_x;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    bg_line_fetcher #(.LINE_WIDTH(160), .VRAM_AW(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ly        (ly),
        .scx       (scx),
        .scy       (scy),
        .lcdc      (lcdc),
        .bgp       (bgp),
        .vram_req  (vram_req),
        .vram_addr (vram_addr),
        .vram_ack  (vram_ack),
        .vram_data (vram_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .busy      (busy),
        .line_done (line_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int map_at(int lc, int y, int c);
        int base;
        base = ((lc & 8) != 0) ? 'h1C00 : 'h1800;
        return base + (y / 8) * 32 + (c % 32);
    endfunction

    function automatic int row_at(int t, int lc, int y);
        int base;
        if ((lc & 'h10) != 0) base = t * 16;
        else base = 'h1000 + ((t >= 128) ? t - 256 : t) * 16;
        return (base + (y % 8) * 2) & 'h1FFF;
    endfunction

    function automatic int ref_shade(int l, int sx, int sy, int lc,
                                     int bp, int px);
        int y, x, t, r, lo, hi, b, id;
        if ((lc & 1) == 0) return bp & 3;
        y  = (l + sy) % 256;
        x  = (sx + px) % 256;
        t  = mem[map_at(lc, y, x / 8)];
        r  = row_at(t, lc, y);
        lo = mem[r];
        hi = mem[(r + 1) & 'h1FFF];
        b  = 7 - (x % 8);
        id = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
        return (bp >> (2 * id)) & 3;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_line(input int l, input int sx, input int sy,
                            input int lc, input int bp, input int rmode,
                            input int dmax, input int abort_at,
                            input bit measure);
        int  exp_pix [160];
        int  exp_reqs [$];
        int  tiles, y, t, r, ma;
        int  xfers, dones, busy_cyc, done_cyc, addr_bad, stall_bad;
        int  req_bad, w;
        int  cur_addr;
        bit  pending, stalled, finished;
        logic [1:0] st_d;
        logic [7:0] st_x;

        for (int p = 0; p < 160; p++)
            exp_pix[p] = ref_shade(l, sx, sy, lc, bp, p);
        tiles = ((lc & 1) != 0) ? (((sx % 8) + 159) / 8) + 1 : 0;
        y = (l + sy) % 256;
        for (int n = 0; n < tiles; n++) begin
            ma = map_at(lc, y, (sx / 8) + n);
            t  = mem[ma];
            r  = row_at(t, lc, y);
            exp_reqs.push_back(ma);
            exp_reqs.push_back(r);
            exp_reqs.push_back((r + 1) & 'h1FFF);
        end

        last_reqs.delete();
        xfers = 0; dones = 0; busy_cyc = 0; done_cyc = 0;
        addr_bad = 0; stall_bad = 0; req_bad = 0; w = 0;
        cur_addr = 0; pending = 0; stalled = 0; finished = 0;
        st_d = 0; st_x = 0;

        @(negedge clk);
        vram_ack = 0; pix_ready = 0;
        ly = 8'(l); scx = 8'(sx); scy = 8'(sy);
        lcdc = 8'(lc); bgp = 8'(bp);
        start = 1;

        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 0;
                check("busy_after_start", busy, 1);
                ly = 8'($urandom); scx = 8'($urandom);
                scy = 8'($urandom); lcdc = 8'($urandom);
                bgp = 8'($urandom);
            end
            if (cyc == 40) start = 1;
            if (cyc == 41) start = 0;
            if (busy) busy_cyc++;

            if (vram_req) begin
                if (!pending) begin
                    pending  = 1;
                    cur_addr = int'(vram_addr);
                    w        = $urandom_range(0, dmax);
                end else if (int'(vram_addr) != cur_addr) begin
                    addr_bad++;
                end
                if (w == 0) begin
                    vram_ack  = 1;
                    vram_data = mem[vram_addr];
                    last_reqs.push_back(int'(vram_addr));
                    pending   = 0;
                end else begin
                    vram_ack = 0;
                    w--;
                end
            end else begin
                vram_ack = 0;
                if (pending) req_bad++;
                pending = 0;
            end

            if (stalled) begin
                if (!pix_valid || pix_data !== st_d || pix_x !== st_x)
                    stall_bad++;
            end
            pix_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (pix_valid) begin
                if (pix_ready) begin
                    if (xfers == 0) begin
                        first_d = pix_data;
                        first_x = pix_x;
                    end
                    if (xfers < 160) begin
                        check("pix_x", pix_x, xfers);
                        check("pix_data", pix_data, exp_pix[xfers]);
                    end
                    xfers++;
                end else begin
                    stalled = 1;
                    st_d    = pix_data;
                    st_x    = pix_x;
                end
            end

            if (line_done) begin
                dones++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
            if (dones > 0 && cyc >= done_cyc + 3) finished = 1;

            if (abort_at >= 0 && xfers == abort_at) begin
                rst_n = 0;
                @(negedge clk);
                check("abort_outputs",
                      {vram_req, vram_addr, pix_valid, pix_data,
                       pix_x, busy, line_done}, 0);
                rst_n = 1;
                vram_ack = 0;
                pix_ready = 0;
                return;
            end
        end

        check("line_finished", finished, 1);
        check("xfer_count", xfers, 160);
        check("done_pulses", dones, 1);
        check("addr_stable", addr_bad, 0);
        check("req_held", req_bad, 0);
        check("stall_stable", stall_bad, 0);
        check("req_count", last_reqs.size(), exp_reqs.size());
        begin
            int bad = 0;
            for (int i = 0; i < exp_reqs.size(); i++)
                if (i >= last_reqs.size() || last_reqs[i] != exp_reqs[i])
                    bad++;
            check("req_sequence", bad, 0);
        end
        // Each tile costs three zero-wait reads plus two forced gaps.
        if (measure) check("busy_cycles", busy_cyc, 160 + 5 * tiles);
        vram_ack = 0;
        pix_ready = 0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; start = 0; ly = 0; scx = 0; scy = 0;
        lcdc = 0; bgp = 0; vram_ack = 0; vram_data = 0;
        pix_ready = 0;
        fill_mem();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {vram_req, vram_addr, pix_valid, pix_data,
               pix_x, busy, line_done}, 0);
        rst_n = 1;
        vram_ack = 1;
        vram_data = 8'hA5;
        @(negedge clk);
        vram_ack = 0;
        @(negedge clk);
        check("idle_ack_ignored", {busy, vram_req, pix_valid}, 0);

        mem['h1800] = 8'h01;
        mem['h0010] = 8'hFF;
        mem['h0011] = 8'h00;
        run_line(0, 0, 0, 'h91, 'hE4, 0, 0, -1, 1);
        check("t1_req0", last_reqs[0], 'h1800);
        check("t1_req1", last_reqs[1], 'h0010);
        check("t1_req2", last_reqs[2], 'h0011);
        check("t1_first_pix", first_d, 1);

        mem['h1800] = 8'h80;
        run_line(3, 0, 0, 'h81, 'hE4, 0, 0, -1, 1);
        check("t2_lo_neg", last_reqs[1], 'h0806);
        check("t2_hi_neg", last_reqs[2], 'h0807);
        mem['h1800] = 8'h00;
        run_line(3, 0, 0, 'h81, 'hE4, 1, 3, -1, 0);
        check("t2_lo_zero", last_reqs[1], 'h1006);

        run_line(3, 'h05, 'hFE, 'h91, 'h1B, 0, 0, -1, 1);
        check("t3_map0", last_reqs[0], 'h1800);
        check("t3_first_x", first_x, 0);
        run_line(0, 'hF8, 0, 'h91, 'hE4, 1, 2, -1, 0);
        check("t3_wrap_col31", last_reqs[0], 'h181F);
        check("t3_wrap_col0", last_reqs[3], 'h1800);

        for (int i = 0; i < 6; i++) begin
            fill_mem();
            run_line($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255),
                     int'(($urandom & 'h18) | 'h81),
                     $urandom_range(0, 255), 1, 5, -1, 0);
        end
        run_line($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), 'h99,
                 $urandom_range(0, 255), 0, 0, -1, 1);

        run_line(7, 3, 9, 'h90, 'h1B, 0, 0, -1, 1);
        check("bg_off_shade", first_d, 3);
        run_line(7, 3, 9, 'h98, 'h1B, 1, 5, -1, 0);

        run_line(20, 13, 40, 'h91, 'hD2, 1, 4, 50, 0);
        repeat (2) @(negedge clk);
        check("post_abort_idle", {busy, vram_req}, 0);
        run_line(20, 13, 40, 'h91, 'hD2, 1, 4, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
